// File: rtl/ram_scan_reader_if.sv
// Bus bundle for ram_scan_reader: RAM read port plus the valid/ready word output stream.
// The master modport is the scanner's side of the bundle; the slave modport is the RAM/consumer side.
interface ram_scan_reader_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 4
) ();
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [ADDR_WIDTH-1:0] out_addr;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output rd_addr,
      input  rd_data,
      output out_addr,
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  rd_addr,
      output rd_data,
      input  out_addr,
      input  out_data,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/ram_scan_reader.sv
// Scans a latency-READ_LATENCY RAM from address 0 upwards and presents each word for DWELL_CYCLES.
// Define RAM_SCAN_CONTINUOUS_EN to wrap back to address 0 at the end instead of stopping in DONE.
module ram_scan_reader #(
   parameter int ADDR_WIDTH   = 5,
   parameter int DATA_WIDTH   = 4,
   parameter int READ_LATENCY = 2,
   parameter int DWELL_CYCLES = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic busy,
   output logic done,
   ram_scan_reader_if.master bus
);

   localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_WAIT    = 3'd2,
      S_PRESENT = 3'd3,
      S_DWELL   = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t                state_q;
   logic [1:0]            lat_cnt_q;
   logic [DW_W-1:0]       dwell_cnt_q;
   logic [ADDR_WIDTH-1:0] rd_addr_q;
   logic [ADDR_WIDTH-1:0] out_addr_q;
   logic [DATA_WIDTH-1:0] out_data_q;
   logic                  out_valid_q;
   logic                  busy_q;
   logic                  done_q;

   assign bus.rd_addr   = rd_addr_q;
   assign bus.out_addr  = out_addr_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign busy          = busy_q;
   assign done          = done_q;

   // Scan FSM; rd_addr only moves on the edge that enters ISSUE so the RAM pipeline sees a stable address.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         lat_cnt_q   <= 2'd0;
         dwell_cnt_q <= '0;
         rd_addr_q   <= '0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  rd_addr_q <= '0;
                  busy_q    <= 1'b1;
                  done_q    <= 1'b0;
                  state_q   <= S_ISSUE;
               end else begin
                  state_q   <= state_q;
               end
            end
            S_ISSUE: begin
               lat_cnt_q <= 2'(READ_LATENCY - 1);
               state_q   <= S_WAIT;
            end
            S_WAIT: begin
               if (lat_cnt_q == 2'd0) begin
                  out_data_q  <= bus.rd_data;
                  out_addr_q  <= rd_addr_q;
                  out_valid_q <= 1'b1;
                  state_q     <= S_PRESENT;
               end else begin
                  lat_cnt_q   <= lat_cnt_q - 2'd1;
               end
            end
            S_PRESENT: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  dwell_cnt_q <= DW_W'(DWELL_CYCLES - 1);
                  state_q     <= S_DWELL;
               end else begin
                  out_valid_q <= 1'b1;
               end
            end
            S_DWELL: begin
               if (dwell_cnt_q != '0) begin
                  dwell_cnt_q <= dwell_cnt_q - DW_W'(1);
               end else if (rd_addr_q != {ADDR_WIDTH{1'b1}}) begin
                  rd_addr_q   <= rd_addr_q + ADDR_WIDTH'(1);
                  state_q     <= S_ISSUE;
               end else begin
`ifdef RAM_SCAN_CONTINUOUS_EN
                  rd_addr_q   <= '0;
                  state_q     <= S_ISSUE;
`else
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  state_q     <= S_DONE;
`endif
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               done_q      <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_scan_reader.sv
// Directed bench for ram_scan_reader: 32x4 RAM model (latency 2, word[a]=a[3:0]^4'hA), dwell 3.
// Build with RAM_SCAN_CONTINUOUS_EN defined to exercise the wrap-around end of scan.
module tb_ram_scan_reader;
   localparam int AW = 5;
   localparam int DW = 4;
   localparam int WORD_CYCLES = 1 + 2 + 1 + 3;

   logic clk = 1'b0;
   logic reset;
   logic start;
   logic busy;
   logic done;
   int   n_total = 0;
   int   n_bad   = 0;
   int   cyc     = 0;
   int   last_rise;
   bit   done_seen = 1'b0;

   ram_scan_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   ram_scan_reader #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2), .DWELL_CYCLES(3)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) if (done) done_seen <= 1'b1;

   // RAM model: registered address, registered data, preloaded contents
   logic [3:0] mem [32];
   logic [4:0] ram_addr_q = 5'd0;
   logic [3:0] ram_data_q = 4'd0;
   initial for (int i = 0; i < 32; i++) mem[i] = 4'(i) ^ 4'hA;
   always @(posedge clk) begin
      ram_addr_q <= bus.rd_addr;
      ram_data_q <= mem[ram_addr_q];
   end
   assign bus.rd_data = ram_data_q;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input int limit, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < limit && !ok; k++) begin
         @(negedge clk);
         if (bus.out_valid) ok = 1'b1;
      end
      check("valid_seen", 32'(ok), 32'd1);
   endtask

   task automatic wait_low(input int limit);
      bit low;
      low = 1'b0;
      for (int k = 0; k < limit && !low; k++) begin
         @(negedge clk);
         if (!bus.out_valid) low = 1'b1;
      end
      check("valid_dropped", 32'(low), 32'd1);
   endtask

   initial begin
      bit ok;
      int n;
      int vcount;
      reset = 1'b0;
      start = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
      check("rst_out_addr", 32'(bus.out_addr), 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'd0);
      @(negedge clk) reset = 1'b1;

      // first word latency: the edge that samples start counts as clock 1
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n = 1;
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(posedge clk);
         #1 n++;
         if (bus.out_valid) ok = 1'b1;
      end
      check("first_latency", 32'(n), 32'd4);
      check("busy_in_scan", 32'(busy), 32'd1);
      last_rise = cyc;

      for (int a = 0; a < 32; a++) begin
         if (a > 0) begin
            wait_valid(40, ok);
            if (a != 6) check("word_period", 32'(cyc - last_rise), 32'(WORD_CYCLES));
            last_rise = cyc;
         end
         check("out_addr", 32'(bus.out_addr), 32'(a));
         check("out_data", 32'(bus.out_data), 32'(4'(a) ^ 4'hA));
         check("rd_addr_stable", 32'(bus.rd_addr), 32'(a));
         if (a == 5) begin
            bus.out_ready = 1'b0;
            for (int k = 0; k < 10; k++) begin
               @(negedge clk);
               check("bp_valid", 32'(bus.out_valid), 32'd1);
               check("bp_addr", 32'(bus.out_addr), 32'd5);
               check("bp_data", 32'(bus.out_data), 32'hF);
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            check("bp_transfer", 32'(bus.out_valid), 32'd0);
         end else if (a == 7) begin
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            wait_low(20);
         end else begin
            wait_low(20);
         end
      end

`ifdef RAM_SCAN_CONTINUOUS_EN
      wait_valid(40, ok);
      check("wrap_addr", 32'(bus.out_addr), 32'd0);
      check("wrap_data", 32'(bus.out_data), 32'hA);
      check("wrap_busy", 32'(busy), 32'd1);
`else
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         if (done) ok = 1'b1;
      end
      check("end_done", 32'(done), 32'd1);
      check("end_busy", 32'(busy), 32'd0);
      check("end_rd_addr", 32'(bus.rd_addr), 32'd31);
      check("end_out_addr", 32'(bus.out_addr), 32'd31);
      check("end_out_data", 32'(bus.out_data), 32'h5);
`endif

      // restart, then abort asynchronously in the first WAIT cycle of address 12
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 300 && !ok; k++) begin
         @(negedge clk);
         if (bus.rd_addr == 5'd12) ok = 1'b1;
      end
      check("reach_addr12", 32'(ok), 32'd1);
      @(negedge clk);
      #1 reset = 1'b0;
      #1;
      check("async_valid", 32'(bus.out_valid), 32'd0);
      check("async_rd_addr", 32'(bus.rd_addr), 32'd0);
      check("async_busy", 32'(busy), 32'd0);
      check("async_out_addr", 32'(bus.out_addr), 32'd0);
      @(negedge clk) reset = 1'b1;
      vcount = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.out_valid) vcount++;
      end
      check("no_word_after_reset", 32'(vcount), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_valid(20, ok);
      check("restart_addr", 32'(bus.out_addr), 32'd0);
      check("restart_data", 32'(bus.out_data), 32'hA);
`ifdef RAM_SCAN_CONTINUOUS_EN
      check("done_never", 32'(done_seen), 32'd0);
`else
      check("done_was_seen", 32'(done_seen), 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
